triroc_sc_loader: RTL and testbench

//  Slow-control master that sits directly upstream of the TRIROC configuration shift register.

---
 rtl/triroc_sc_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_triroc_sc_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/triroc_sc_loader.sv
// -----------------------------------------------------------------------------
// triroc_sc_loader
//
// Slow-control master for the TRIROC configuration shift register. A parallel
// config word is taken over a valid/ready handshake, shifted LSB-first onto
// sr_in while the displaced chain contents are captured from sr_out, and then
// latched into the chip with a single-cycle active-low load_sc strobe. When
// VERIFY is set, the same word is shifted a second time and the loop-back is
// compared bit by bit.
//
// Parameters
//   WIDTH     config chain length in bits (>= 2)
//   VERIFY    1: run a verifying second pass after load, 0: skip it
//   LOAD_GAP  idle cycles between the last shift cycle and load_sc (>= 1)
//
// Ports
//   ck_sr        in   slow-control clock, rising edge
//   rstb_sr      in   asynchronous active-low reset
//   cfg_data     in   config word, bit 0 shifted first
//   cfg_valid    in   cfg_data valid
//   cfg_ready    out  loader idle and accepting a word
//   sr_in        out  serial data to the chain (registered)
//   sr_out       in   serial data returned from the end of the chain
//   select       out  chain select, held at 1 (slow-control register)
//   load_sc      out  active-low load strobe, one cycle wide
//   busy         out  loader is in any state other than IDLE
//   done         out  one-cycle pulse at the end of a transaction
//   match        out  verify result, valid with done, held until next accept
//   rdback_data  out  previous chain contents captured during the first pass
// -----------------------------------------------------------------------------
module triroc_sc_loader #(
    parameter int WIDTH    = 16,
    parameter int VERIFY   = 1,
    parameter int LOAD_GAP = 2
) (
    input  logic             ck_sr,
    input  logic             rstb_sr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             sr_in,
    input  logic             sr_out,
    output logic             select,
    output logic             load_sc,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [WIDTH-1:0] rdback_data
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (LOAD_GAP > 1) ? $clog2(LOAD_GAP + 1) : 1;

    localparam logic [CW-1:0]    CNT_ZERO  = '0;
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [GW-1:0]    GAP_ZERO  = '0;
    localparam logic [GW-1:0]    GAP_ONE   = GW'(1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'(LOAD_GAP - 1);
    localparam logic [WIDTH-1:0] VEC_ZERO  = '0;
    localparam logic [WIDTH-1:0] VEC_BIT0  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             VERIFY_EN = (VERIFY != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_GAP    = 3'd2,
        ST_LOAD   = 3'd3,
        ST_VSHIFT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t           state_r,  state_s;
    logic [CW-1:0]    cnt_r,    cnt_s;
    logic [GW-1:0]    gap_r,    gap_s;
    logic [WIDTH-1:0] shadow_r, shadow_s;
    logic [WIDTH-1:0] rdback_r, rdback_s;
    logic [WIDTH-1:0] drive_vec_s;
    logic [WIDTH-1:0] verify_vec_s;
    logic [WIDTH-1:0] sample_vec_s;
    logic             match_acc_r, match_acc_s;
    logic             sr_in_r,     sr_in_s;
    logic             load_sc_r,   load_sc_s;
    logic             busy_r,      busy_s;
    logic             ready_r,     ready_s;
    logic             done_r,      done_s;
    logic             match_r,     match_s;
    logic             select_r;
    logic             accept_s;

    assign accept_s = cfg_valid & ready_r & (state_r == ST_IDLE);

    // Next-state and counter logic for the transaction sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        gap_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_GAP;
                    gap_s   = GAP_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_s = ST_LOAD;
                end else begin
                    gap_s = gap_r + GAP_ONE;
                end
            end
            ST_LOAD: begin
                if (VERIFY_EN) begin
                    state_s = ST_VSHIFT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_VSHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                gap_s   = GAP_ZERO;
            end
        endcase
    end

    // Output and datapath next values; outputs are derived from the next
    // state so that they are registered yet aligned with the state they show.
    always_comb begin
        if (accept_s) begin
            shadow_s = cfg_data;
        end else begin
            shadow_s = shadow_r;
        end

        // Bit to drive next cycle and bit being returned this cycle.
        drive_vec_s  = shadow_s >> cnt_s;
        verify_vec_s = shadow_r >> cnt_r;
        sample_vec_s = VEC_ZERO;
        sample_vec_s[0] = sr_out;

        if ((state_s == ST_SHIFT) || (state_s == ST_VSHIFT)) begin
            sr_in_s = drive_vec_s[0];
        end else begin
            sr_in_s = 1'b0;
        end

        load_sc_s = (state_s != ST_LOAD);
        busy_s    = (state_s != ST_IDLE);
        ready_s   = (state_s == ST_IDLE);
        done_s    = (state_s == ST_DONE);

        // First pass: the bit now on sr_out is the old chain bit cnt_r.
        if (state_r == ST_SHIFT) begin
            rdback_s = (rdback_r & ~(VEC_BIT0 << cnt_r)) | (sample_vec_s << cnt_r);
        end else begin
            rdback_s = rdback_r;
        end

        if (accept_s) begin
            match_acc_s = 1'b1;
        end else if ((state_r == ST_VSHIFT) && (sr_out != verify_vec_s[0])) begin
            match_acc_s = 1'b0;
        end else begin
            match_acc_s = match_acc_r;
        end

        // match_acc_s already includes the final loop-back bit here.
        if (accept_s) begin
            match_s = 1'b0;
        end else if (state_s == ST_DONE) begin
            if (VERIFY_EN) begin
                match_s = match_acc_s;
            end else begin
                match_s = 1'b1;
            end
        end else begin
            match_s = match_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge ck_sr or negedge rstb_sr) begin
        if (!rstb_sr) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            gap_r       <= GAP_ZERO;
            shadow_r    <= VEC_ZERO;
            rdback_r    <= VEC_ZERO;
            match_acc_r <= 1'b0;
            sr_in_r     <= 1'b0;
            load_sc_r   <= 1'b1;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            match_r     <= 1'b0;
            select_r    <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            gap_r       <= gap_s;
            shadow_r    <= shadow_s;
            rdback_r    <= rdback_s;
            match_acc_r <= match_acc_s;
            sr_in_r     <= sr_in_s;
            load_sc_r   <= load_sc_s;
            busy_r      <= busy_s;
            ready_r     <= ready_s;
            done_r      <= done_s;
            match_r     <= match_s;
            select_r    <= 1'b1;
        end
    end

    assign cfg_ready   = ready_r;
    assign sr_in       = sr_in_r;
    assign select      = select_r;
    assign load_sc     = load_sc_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign match       = match_r;
    assign rdback_data = rdback_r;

endmodule

// File: tb/tb_triroc_sc_loader.sv
// -----------------------------------------------------------------------------
// tb_triroc_sc_loader
//
// Self-checking bench for triroc_sc_loader. A behavioural model of the TRIROC
// chain (a WIDTH-bit FIFO, sr_out = oldest bit) sits on the serial pins; the
// expected waveform of every transaction is computed from the cycle schedule
// accept -> WIDTH shift -> LOAD_GAP gap -> load -> WIDTH verify -> done.
// -----------------------------------------------------------------------------
module tb_triroc_sc_loader;

    localparam int W  = 16;
    localparam int G  = 2;
    localparam int V  = 1;
    localparam int LOAD_K    = W + G + 1;
    localparam int VS_FIRST  = W + G + 2;
    localparam int VS_LAST   = W + G + 1 + V * W;
    localparam int NT        = W + G + 2 + V * W;

    logic         ck_sr;
    logic         rstb_sr;
    logic [W-1:0] cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         sr_in;
    logic         sr_out;
    logic         select;
    logic         load_sc;
    logic         busy;
    logic         done;
    logic         match;
    logic [W-1:0] rdback_data;

    logic [W-1:0] chain;
    logic         stuck_r;
    logic         tb_match;
    int           checks;
    int           failures;

    assign sr_out = stuck_r ? 1'b0 : chain[0];

    triroc_sc_loader #(.WIDTH(W), .VERIFY(V), .LOAD_GAP(G)) dut (
        .ck_sr       (ck_sr),
        .rstb_sr     (rstb_sr),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .sr_in       (sr_in),
        .sr_out      (sr_out),
        .select      (select),
        .load_sc     (load_sc),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .rdback_data (rdback_data)
    );

    initial ck_sr = 1'b0;
    always #5 ck_sr = ~ck_sr;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_ready"},  32'(cfg_ready),   32'd1);
        chk_eq({tag, "_busy"},   32'(busy),        32'd0);
        chk_eq({tag, "_load"},   32'(load_sc),     32'd1);
        chk_eq({tag, "_srin"},   32'(sr_in),       32'd0);
        chk_eq({tag, "_done"},   32'(done),        32'd0);
        chk_eq({tag, "_match"},  32'(match),       32'd0);
        chk_eq({tag, "_rdback"}, 32'(rdback_data), 32'd0);
        chk_eq({tag, "_select"}, 32'(select),      32'd1);
    endtask

    // One transaction; abort_at > 0 asserts reset at that cycle instead.
    task automatic run_word(input logic [W-1:0] word, input bit stuck,
                            input bit hold, input int abort_at);
        int           waits;
        bit           ok;
        bit           m;
        logic         obs;
        logic [W-1:0] rd_exp;
        logic         exp_sr;
        int           i;
        waits  = 0;
        ok     = 1'b0;
        m      = 1'b1;
        rd_exp = '0;
        while (!ok && waits < 50) begin
            @(negedge ck_sr);
            cfg_data  = word;
            cfg_valid = 1'b1;
            if (cfg_ready) ok = 1'b1;
            else waits++;
        end
        if (!ok) begin
            chk_eq("ready_timeout", 32'd0, 32'd1);
            cfg_valid = 1'b0;
            return;
        end
        if (hold) chk_eq("idle_gap", 32'(waits), 32'd0);
        chk_eq("idle_busy",  32'(busy),    32'd0);
        chk_eq("idle_done",  32'(done),    32'd0);
        chk_eq("idle_load",  32'(load_sc), 32'd1);
        chk_eq("idle_match", 32'(match),   32'(tb_match));
        @(posedge ck_sr);
        #1;
        if (hold) cfg_data = W'($urandom);
        else cfg_valid = 1'b0;
        tb_match = 1'b0;
        for (int k = 1; k <= NT; k++) begin
            @(negedge ck_sr);
            if (k <= W) exp_sr = word[k-1];
            else if (k >= VS_FIRST && k <= VS_LAST) exp_sr = word[k-VS_FIRST];
            else exp_sr = 1'b0;
            chk_eq("sr_in",   32'(sr_in),     32'(exp_sr));
            chk_eq("load_sc", 32'(load_sc),   (k == LOAD_K) ? 32'd0 : 32'd1);
            chk_eq("busy",    32'(busy),      32'd1);
            chk_eq("ready",   32'(cfg_ready), 32'd0);
            chk_eq("done",    32'(done),      (k == NT) ? 32'd1 : 32'd0);
            chk_eq("select",  32'(select),    32'd1);
            if (k == NT) begin
                tb_match = m;
                chk_eq("match_done", 32'(match),       32'(m));
                chk_eq("rdback",     32'(rdback_data), 32'(rd_exp));
            end else begin
                chk_eq("match_busy", 32'(match), 32'd0);
            end
            if (k == abort_at) begin
                rstb_sr = 1'b0;
                #1;
                tb_match = 1'b0;
                chk_reset_outputs("abort");
                for (int r = 0; r < 3; r++) begin
                    @(negedge ck_sr);
                    chk_eq("abort_hold_load", 32'(load_sc), 32'd1);
                    chk_eq("abort_hold_busy", 32'(busy),    32'd0);
                end
                rstb_sr   = 1'b1;
                cfg_valid = 1'b0;
                return;
            end
            @(posedge ck_sr);
            #1;
            if (k <= W) begin
                rd_exp[k-1] = chain[0];
                chain = {word[k-1], chain[W-1:1]};
            end else if (k >= VS_FIRST && k <= VS_LAST) begin
                i   = k - VS_FIRST;
                obs = stuck_r ? 1'b0 : chain[0];
                if (obs !== word[i]) m = 1'b0;
                chain = {word[i], chain[W-1:1]};
            end
            stuck_r = stuck && (k + 1 >= VS_FIRST) && (k + 1 <= VS_LAST);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        chain     = '0;
        stuck_r   = 1'b0;
        tb_match  = 1'b0;
        cfg_data  = '0;
        cfg_valid = 1'b0;
        rstb_sr   = 1'b0;

        // Reset held for 4 cycles; load_sc must never drop.
        for (int r = 0; r < 4; r++) begin
            @(negedge ck_sr);
            chk_eq("rst_load", 32'(load_sc), 32'd1);
        end
        chk_reset_outputs("rst");
        rstb_sr = 1'b1;
        @(negedge ck_sr);
        chk_reset_outputs("post_rst");
        @(posedge ck_sr);
        #1;

        run_word(16'hDAF1, 1'b0, 1'b0, 0);
        run_word(16'h1234, 1'b0, 1'b0, 0);
        run_word(16'h8001, 1'b1, 1'b0, 0);
        run_word(W'($urandom), 1'b0, 1'b0, 7);
        for (int n = 0; n < 3; n++) run_word(W'($urandom), 1'b0, 1'b0, 0);
        for (int n = 0; n < 4; n++) run_word(W'($urandom), 1'b0, 1'b1, 0);
        cfg_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge ck_sr);
            chk_eq("final_idle_busy", 32'(busy),    32'd0);
            chk_eq("final_idle_load", 32'(load_sc), 32'd1);
        end
        chk_eq("final_match", 32'(match), 32'(tb_match));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
